// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns single-beat register commands into one AXI-Lite
// transaction at a time and returns read data, response code and timeout status.
module axil_cmd_master #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response side
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI-Lite write address / data / response
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // AXI-Lite read address / data
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_t;

  localparam int unsigned    CNT_W      = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Last count value before expiry: valids drop the cycle after this one.
  localparam logic [CNT_W-1:0] TO_LAST  =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  state_t              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic active, timeout_hit;

  // All handshake-facing outputs decode straight from registered state.
  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign m_axi_awvalid = (state_q == S_WR_AW_W) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == S_WR_AW_W) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WR_B);
  assign m_axi_arvalid = (state_q == S_RD_AR);
  assign m_axi_rready  = (state_q == S_RD_R);
  assign rsp_valid     = (state_q == S_RSP);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign rsp_hs = rsp_valid && rsp_ready;

  assign active      = (state_q != S_IDLE) && (state_q != S_RSP);
  assign timeout_hit = TIMEOUT_EN && active && (cnt_q >= TO_LAST);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    if (active && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          cnt_d         = '0;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b00;
          rsp_timeout_d = 1'b0;
          state_d       = cmd_we ? S_WR_AW_W : S_RD_AR;
        end
      end
      S_WR_AW_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (timeout_hit) begin
          state_d = S_RSP;
        end else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_WR_B;
        end
      end
      S_WR_B: begin
        if (b_hs) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end else if (timeout_hit) begin
          state_d = S_RSP;
        end
      end
      S_RD_AR: begin
        if (timeout_hit) state_d = S_RSP;
        else if (ar_hs)  state_d = S_RD_R;
      end
      S_RD_R: begin
        if (r_hs) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = S_RSP;
        end else if (timeout_hit) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completed final handshake wins over a coincident expiry.
    if (timeout_hit && !b_hs && !r_hs) begin
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: cycle-accurate AXI slave stimulus plus a
// response scoreboard filled when each command is issued.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [5:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_cmd_master #(.ADDR_W(6), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  logic [95:0] all_outs;
  assign all_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                     m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata,
                     m_axi_wstrb, m_axi_wvalid, m_axi_bready, m_axi_araddr,
                     m_axi_arprot, m_axi_arvalid, m_axi_rready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp, input logic to);
    rsp_t e;
    e.rdata = rdata;
    e.resp  = resp;
    e.to    = to;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for a response, scores it against the oldest entry, then consumes it.
  task automatic take_rsp(input string tag);
    rsp_t e;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    check({tag, " sb_has_entry"}, sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
      check({tag, " rsp_resp"}, rsp_resp, e.resp);
      check({tag, " rsp_timeout"}, rsp_timeout, e.to);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;

    // Reset state
    tick(); tick();
    check("reset all_outs", all_outs, 96'h0);
    rst = 1'b0;
    #1;
    check("reset cmd_ready", cmd_ready, 1'b1);

    // 1: zero-wait write
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h04; cmd_wdata = 32'h0000_00A5; cmd_wstrb = 4'hF;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    push_exp(32'h0, 2'b00, 1'b0);
    check("t1 cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("t1 T+1 aw/w/b", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
    check("t1 awaddr", m_axi_awaddr, 6'h04);
    check("t1 wdata", m_axi_wdata, 32'h0000_00A5);
    check("t1 wstrb", m_axi_wstrb, 4'hF);
    check("t1 prot", {m_axi_awprot, m_axi_arprot}, 6'h0);
    tick();
    check("t1 T+2 aw/w/b", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    check("t1 T+2 rsp_valid", rsp_valid, 1'b0);
    tick();
    m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("t1 T+3 rsp_valid", rsp_valid, 1'b1);
    check("t1 T+3 bready", m_axi_bready, 1'b0);
    take_rsp("t1");
    check("t1 back to idle", {cmd_ready, rsp_valid}, 2'b10);

    // 2: write with W completing three cycles after AW
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h08; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'h3;
    m_axi_awready = 1'b1; m_axi_wready = 1'b0;
    push_exp(32'h0, 2'b01, 1'b0);
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'hFFFF_FFFF;
    check("t2 T+1 aw/w/b", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
    tick();
    m_axi_awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2 w held aw/w/b", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
      check("t2 w held wdata", {m_axi_wdata, m_axi_wstrb}, {32'h1234_5678, 4'h3});
      if (i == 2) m_axi_wready = 1'b1;
      tick();
    end
    m_axi_wready = 1'b0;
    check("t2 b phase aw/w/b", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01;
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    take_rsp("t2");

    // 3: read with arready delay 2 and rvalid delay
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 6'h10;
    m_axi_rdata = 32'h1111_1111;
    push_exp(32'hDEAD_BEEF, 2'b00, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("t3 arvalid/rready", {m_axi_arvalid, m_axi_rready}, 2'b10);
    check("t3 araddr", m_axi_araddr, 6'h10);
    tick();
    check("t3 arvalid wait", m_axi_arvalid, 1'b1);
    tick();
    m_axi_arready = 1'b1;
    check("t3 arvalid at hs", m_axi_arvalid, 1'b1);
    tick();
    m_axi_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3 r wait arvalid/rready", {m_axi_arvalid, m_axi_rready}, 2'b01);
      tick();
    end
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00;
    check("t3 rready at hs", m_axi_rready, 1'b1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'h2222_2222;
    take_rsp("t3");

    // 4: read timeout; unsolicited R beats must be ignored
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 6'h20;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rresp = 2'b01;
    push_exp(32'h0, 2'b10, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4 arvalid/rready", {m_axi_arvalid, m_axi_rready}, 2'b10);
      tick();
    end
    check("t4 expired arvalid/rready/rsp", {m_axi_arvalid, m_axi_rready, rsp_valid}, 3'b001);
    m_axi_rvalid = 1'b0;
    take_rsp("t4");

    // 5: response back-pressure with the next command already pending
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h0C; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01;
    push_exp(32'h0, 2'b01, 1'b0);
    tick();
    cmd_we = 1'b0; cmd_addr = 6'h18;
    push_exp(32'hCAFE_0005, 2'b00, 1'b0);
    check("t5 busy cmd_ready", cmd_ready, 1'b0);
    tick();
    check("t5 wr_b cmd_ready/bready", {cmd_ready, m_axi_bready}, 2'b01);
    tick();
    m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5 hold valid/cmd_ready", {rsp_valid, cmd_ready}, 2'b10);
      check("t5 hold fields", {rsp_rdata, rsp_resp, rsp_timeout}, {32'h0, 2'b01, 1'b0});
      tick();
    end
    take_rsp("t5w");
    check("t5 accept after rsp hs", cmd_ready, 1'b1);
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_0005; m_axi_rresp = 2'b00;
    tick();
    cmd_valid = 1'b0;
    check("t5 read arvalid/araddr", {m_axi_arvalid, m_axi_araddr}, {1'b1, 6'h18});
    tick();
    m_axi_arready = 1'b0;
    check("t5 read rready", m_axi_rready, 1'b1);
    tick();
    m_axi_rvalid = 1'b0;
    take_rsp("t5r");

    // 6: reset while waiting in WR_B with bvalid asserted
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h3C; cmd_wdata = 32'h0000_0077; cmd_wstrb = 4'hF;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("t6 in wr_b bready", m_axi_bready, 1'b1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
    rst = 1'b1;
    tick();
    check("t6 all_outs in reset", all_outs, 96'h0);
    rst = 1'b0;
    #1;
    check("t6 cmd_ready after reset", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6 no rsp after reset", {rsp_valid, m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 4'b0000);
    end
    m_axi_bvalid = 1'b0;
    check("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
